// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
// Sequences one instruction at a time through
// IDLE -> FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITE and generates the
// per-phase enables for the PC, instruction memory, register file, data memory
// and write-back path. FETCH and MEMORY wait on ready handshakes and fall into a
// sticky FAULT state if a wait exceeds TIMEOUT cycles. Halt/run/single-step
// debug control acts only at instruction boundaries (WRITE).
//
// Handshakes: imem_req (dmem_req) is held high for every cycle the sequencer
// waits in FETCH (MEMORY with a load/store); the transfer completes in the
// cycle the matching *_ready is sampled high on the rising clock edge, and the
// sequencer leaves the phase on that edge. Ready wins over a coinciding timeout.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   run                 1 = free-run, 0 = stop at the next instruction boundary
//   step                one-cycle pulse; while halted runs exactly one instruction
//   halt_req            request halt at the next instruction boundary
//   is_mem_op, is_wb    decoded instruction attributes, valid from DECODE onward
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory access complete
//   imem_req, dmem_req  memory requests
//   if_en, id_en, exe_en, mem_en, wb_en   per-phase enables
//   state               current state encoding (debug / checker visibility)
//   halted, fault       state == HALT / state == FAULT (sticky until rst)
//   retire, retire_cnt  one-cycle pulse per completed instruction, and its count
module cpu_phase_sequencer #(
  parameter int RETIRE_W    = 32,
  parameter int TIMEOUT     = 16,
  parameter int BOOT_CYCLES = 1,
  parameter int SKIP_MEM    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic                is_mem_op,
  input  logic                is_wb,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                if_en,
  output logic                id_en,
  output logic                exe_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_EXECUTE = 3'b011,
    S_MEMORY  = 3'b100,
    S_WRITE   = 3'b101,
    S_FAULT   = 3'b110,
    S_HALT    = 3'b111
  } state_t;

  localparam int  WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int  BOOT_N  = (BOOT_CYCLES > 1) ? BOOT_CYCLES : 1;
  localparam int  BOOT_W  = (BOOT_N > 1) ? $clog2(BOOT_N) : 1;
  localparam bit  TMO_EN  = (TIMEOUT > 0);
  localparam bit  SKIP_EN = (SKIP_MEM != 0);
  // Last wait count that is still allowed; one more miss means timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_N - 1);

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [BOOT_W-1:0]     boot_q, boot_d;
  logic                  spend_q, spend_d;   // step_pending
  logic                  hpend_q, hpend_d;   // latched halt request
  logic [RETIRE_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;       // counters clear whenever their phase is left
    boot_d  = '0;
    spend_d = spend_q;
    // A halt_req pulse seen mid-instruction must survive until WRITE, where
    // the boundary decision is made; it never aborts the instruction.
    hpend_d = hpend_q | (halt_req & (state_q != S_HALT));
    cnt_d   = cnt_q;
    case (state_q)
      S_HALT: begin
        hpend_d = 1'b0;
        if (run) begin
          state_d = S_IDLE;
        end else if (step) begin
          state_d = S_IDLE;
          spend_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (boot_q == BOOT_LAST) state_d = S_FETCH;
        else                     boot_d  = boot_q + BOOT_W'(1);
      end
      S_FETCH: begin
        if (imem_ready)                         state_d = S_DECODE;
        else if (TMO_EN && wait_q == WAIT_LAST) state_d = S_FAULT;
        else                                    wait_d  = wait_q + WAIT_W'(1);
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = (is_mem_op || !SKIP_EN) ? S_MEMORY : S_WRITE;
      S_MEMORY: begin
        // Non-memory instructions pass through in a single cycle.
        if (!is_mem_op || dmem_ready)           state_d = S_WRITE;
        else if (TMO_EN && wait_q == WAIT_LAST) state_d = S_FAULT;
        else                                    wait_d  = wait_q + WAIT_W'(1);
      end
      S_WRITE: begin
        cnt_d = cnt_q + RETIRE_W'(1);
        if (!run || halt_req || hpend_q || spend_q) begin
          state_d = S_HALT;
          spend_d = 1'b0;
          hpend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HALT;
      wait_q  <= '0;
      boot_q  <= '0;
      spend_q <= 1'b0;
      hpend_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      boot_q  <= boot_d;
      spend_q <= spend_d;
      hpend_q <= hpend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase outputs: decoded from the registered state plus the handshake and
  // decode inputs, so each enable can only ever be high in its own state.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    if_en    = (state_q == S_FETCH) & imem_ready;
    id_en    = (state_q == S_DECODE);
    exe_en   = (state_q == S_EXECUTE);
    mem_en   = (state_q == S_MEMORY);
    dmem_req = (state_q == S_MEMORY) & is_mem_op;
    wb_en    = (state_q == S_WRITE) & is_wb;
    retire   = (state_q == S_WRITE);
    halted   = (state_q == S_HALT);
    fault    = (state_q == S_FAULT);
  end

  assign state      = state_q;
  assign retire_cnt = cnt_q;

endmodule
